dmem_cache: RTL

- Direct-mapped, write-through, no-write-allocate data cache between the CPU MA stage and the external data memory.
- Consumes the MA-stage address, store data and the 2-bit read/write size codes.
- Returns load data, zero- or sign-extended, to the MA/WB pipeline register.
- Raises busywait to stall the pipeline on misses and on every store.

---
 rtl/dmem_cache_if.sv | 38 +++
 rtl/dmem_cache.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_cache_if.sv
// dmem_cache_if: bundles the CPU-side MA-stage access signals and the
// external data-memory signals of the data cache.
//   CPU side   : address, write_data, mem_read, mem_write, load_unsigned
//                -> read_data, busywait, misaligned
//   Memory side: ext_read, ext_write, ext_address, ext_writedata, ext_byteen
//                <- ext_readdata (128-bit line), ext_busywait
// Modports: slave = the cache itself, master = the surrounding CPU/memory.
interface dmem_cache_if;
    logic [31:0]  address;
    logic [31:0]  write_data;
    logic [1:0]   mem_read;
    logic [1:0]   mem_write;
    logic         load_unsigned;
    logic [31:0]  read_data;
    logic         busywait;
    logic         misaligned;
    logic         ext_read;
    logic         ext_write;
    logic [31:0]  ext_address;
    logic [31:0]  ext_writedata;
    logic [3:0]   ext_byteen;
    logic [127:0] ext_readdata;
    logic         ext_busywait;

    modport slave (
        input  address, write_data, mem_read, mem_write, load_unsigned,
        input  ext_readdata, ext_busywait,
        output read_data, busywait, misaligned,
        output ext_read, ext_write, ext_address, ext_writedata, ext_byteen
    );

    modport master (
        output address, write_data, mem_read, mem_write, load_unsigned,
        output ext_readdata, ext_busywait,
        input  read_data, busywait, misaligned,
        input  ext_read, ext_write, ext_address, ext_writedata, ext_byteen
    );
endinterface

// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped, write-through, no-write-allocate data cache.
// Read hits return data combinationally; read misses fetch a 128-bit line;
// every store is written to memory (and merged into the line on a hit).
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset (clears valid bits and the FSM)
//   bus   - dmem_cache_if.slave: CPU access signals and external memory port
module dmem_cache #(
    parameter int LINES          = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic         clk,
    input  logic         reset,
    dmem_cache_if.slave  bus
);
    localparam int IW        = $clog2(LINES);
    localparam int TW        = 28 - IW;
    localparam int LINE_BITS = 32 * WORDS_PER_LINE;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t state_reg, state_next;
    // Marks the cycle right after a store completes: the pipeline is still
    // presenting that same store, which must not be issued a second time.
    logic   write_done_reg, write_done_next;

    logic [LINES-1:0]     valid_reg;
    logic [TW-1:0]        tag_mem  [LINES];
    logic [LINE_BITS-1:0] data_mem [LINES];

    // Decoded access
    logic          write_req, read_req;
    logic [1:0]    size;
    logic [1:0]    offset;
    logic [1:0]    word_sel;
    logic [IW-1:0] index;
    logic [TW-1:0] tag;
    logic          hit;

    assign write_req = (bus.mem_write != 2'b00);
    assign read_req  = !write_req && (bus.mem_read != 2'b00);
    assign size      = write_req ? bus.mem_write : bus.mem_read;
    assign word_sel  = bus.address[3:2];
    assign index     = bus.address[3+IW:4];
    assign tag       = bus.address[31:4+IW];
    assign hit       = valid_reg[index] && (tag_mem[index] == tag);

    assign bus.misaligned = ((size == 2'b10) && bus.address[0]) ||
                            ((size == 2'b11) && (bus.address[1:0] != 2'b00));

    // Misaligned accesses proceed with the offending low bits cleared.
    always_comb begin
        offset = bus.address[1:0];
        if (size == 2'b10)
            offset = {bus.address[1], 1'b0};
        else if (size == 2'b11)
            offset = 2'b00;
    end

    // Load path
    logic [LINE_BITS-1:0] line;
    logic [31:0]          word;
    logic [7:0]           byte_val;
    logic [15:0]          half_val;
    logic [31:0]          load_val;

    assign line     = data_mem[index];
    assign word     = line[{word_sel, 5'b0} +: 32];
    assign byte_val = word[{offset, 3'b0} +: 8];
    assign half_val = word[{offset[1], 4'b0} +: 16];

    always_comb begin
        load_val = word;
        case (size)
            2'b01: load_val = bus.load_unsigned ? {24'b0, byte_val}
                                                : {{24{byte_val[7]}}, byte_val};
            2'b10: load_val = bus.load_unsigned ? {16'b0, half_val}
                                                : {{16{half_val[15]}}, half_val};
            default: load_val = word;
        endcase
    end

    // Store path: lane enables and replicated store data
    logic [3:0]  byteen;
    logic [31:0] wdata_lanes;

    always_comb begin
        byteen      = 4'b0000;
        wdata_lanes = bus.write_data;
        case (bus.mem_write)
            2'b01: begin
                byteen      = 4'b0001 << bus.address[1:0];
                wdata_lanes = {4{bus.write_data[7:0]}};
            end
            2'b10: begin
                byteen      = 4'b0011 << {bus.address[1], 1'b0};
                wdata_lanes = {2{bus.write_data[15:0]}};
            end
            2'b11: begin
                byteen      = 4'b1111;
                wdata_lanes = bus.write_data;
            end
            default: ;
        endcase
    end

    // Store-hit merge: enabled byte lanes replace the cached word, which is
    // then placed back at its word slot in the line.
    logic [31:0]          merged_word;
    logic [LINE_BITS-1:0] merged_line;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged_word[8*gi +: 8] = byteen[gi] ? wdata_lanes[8*gi +: 8]
                                                   : word[8*gi +: 8];
    end

    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
        assign merged_line[32*gi +: 32] = (word_sel == gi[1:0]) ? merged_word
                                                                : line[32*gi +: 32];
    end

    // FSM next-state and outputs
    logic        busy;
    logic        ext_read, ext_write;
    logic [31:0] ext_address;
    logic        fill, store_commit;

    always_comb begin
        state_next      = state_reg;
        write_done_next = 1'b0;
        busy            = 1'b0;
        ext_read        = 1'b0;
        ext_write       = 1'b0;
        ext_address     = 32'h0;
        fill            = 1'b0;
        store_commit    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (write_req && !write_done_reg) begin
                    busy       = 1'b1;
                    state_next = WRITE;
                end else if (read_req && !hit) begin
                    busy       = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy        = 1'b1;
                ext_read    = 1'b1;
                ext_address = {bus.address[31:4], 4'b0};
                if (!bus.ext_busywait) begin
                    fill       = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                busy        = 1'b1;
                ext_write   = 1'b1;
                ext_address = {bus.address[31:2], 2'b0};
                if (!bus.ext_busywait) begin
                    store_commit    = 1'b1;
                    write_done_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // While reset is held the pipeline must see no stall and no data.
    assign bus.busywait      = busy && !reset;
    assign bus.read_data     = (!reset && (state_reg == IDLE) && read_req && hit)
                               ? load_val : 32'h0;
    assign bus.ext_read      = ext_read;
    assign bus.ext_write     = ext_write;
    assign bus.ext_address   = ext_address;
    assign bus.ext_byteen    = ext_write ? byteen : 4'b0000;
    assign bus.ext_writedata = ext_write ? wdata_lanes : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            write_done_reg <= 1'b0;
            valid_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            write_done_reg <= write_done_next;
            if (fill)
                valid_reg[index] <= 1'b1;
        end
    end

    // Tag and data arrays are not cleared by reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[index]  <= tag;
            data_mem[index] <= bus.ext_readdata[LINE_BITS-1:0];
        end else if (store_commit && hit) begin
            data_mem[index] <= merged_line;
        end
    end
endmodule
